// File: rtl/qsn_pkg.sv
// Shared constants, lane-vector type and merge-mask helper for the
// 17-lane inverse QSN shifter.
package qsn_pkg;

    localparam int LANES_17  = 17;
    localparam int QUAN_4    = 4;
    localparam int SHIFT_W_5 = 5;
    localparam int MSG_W     = LANES_17 * QUAN_4;

    typedef logic [LANES_17-1:0][QUAN_4-1:0] lane_vec_t;

    // Bit k set when lane k takes the left-network value (k >= s).
    function automatic logic [LANES_17-2:0] merge_sel(input logic [SHIFT_W_5-1:0] s);
        logic [LANES_17-2:0] m;
        m = '0;
        for (int k = 0; k < LANES_17 - 1; k++) begin
            m[k] = (k >= int'(s));
        end
        return m;
    endfunction

endpackage

// File: rtl/qsn_merge_inv_len17.sv
// Combinational merge of the two half-network outputs: 16 muxed lanes,
// lane 16 always taken from the right network.
module qsn_merge_inv_len17
    import qsn_pkg::*;
(
    input  lane_vec_t               left_lanes,
    input  lane_vec_t               right_lanes,
    input  logic [LANES_17-2:0]     sel,
    output lane_vec_t               merged
);

    always_comb begin
        merged = right_lanes;
        for (int k = 0; k < LANES_17 - 1; k++) begin
            if (sel[k]) begin
                merged[k] = left_lanes[k];
            end
        end
    end

endmodule

// File: rtl/qsn_inv_shift_len17.sv
// Two-stage pipelined inverse cyclic shifter: lane j of the output is
// input lane (j - s) mod 17, with valid/ready flow control.
module qsn_inv_shift_len17
    import qsn_pkg::*;
#(
    parameter int LANES   = LANES_17,
    parameter int QUAN    = QUAN_4,
    parameter int SHIFT_W = SHIFT_W_5
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*QUAN-1:0]   msg_in,
    input  logic [SHIFT_W-1:0]      shift_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*QUAN-1:0]   msg_out,
    output logic                    shift_err
);

    logic                   adv1, adv2, accept, bad_shift;
    logic [SHIFT_W_5-1:0]   s_eff, r_amt;
    logic [MSG_W-1:0]       left_bits, right_bits;
    lane_vec_t              merged;

    logic                   s1_valid_q, s1_valid_d;
    lane_vec_t              s1_left_q, s1_left_d;
    lane_vec_t              s1_right_q, s1_right_d;
    logic [LANES_17-2:0]    s1_sel_q, s1_sel_d;
    logic                   s2_valid_q, s2_valid_d;
    lane_vec_t              s2_data_q, s2_data_d;
    logic                   shift_err_q, shift_err_d;

    always_comb begin
        adv2      = !s2_valid_q || out_ready;
        adv1      = !s1_valid_q || adv2;
        accept    = in_valid && adv1;
        bad_shift = (shift_in >= SHIFT_W_5'(LANES_17));
        s_eff     = bad_shift ? '0 : shift_in;
        r_amt     = (s_eff == '0) ? '0 : SHIFT_W_5'(LANES_17) - s_eff;
    end

    // Left network shifts lanes up by s (zero fill); right network rotates
    // down by 17-s, so it is correct on every lane and lane 16 needs no mux.
    always_comb begin
        left_bits  = msg_in;
        right_bits = msg_in;
        for (int b = 0; b < SHIFT_W_5; b++) begin
            if (s_eff[b]) begin
                left_bits = left_bits << (QUAN_4 * (1 << b));
            end
            if (r_amt[b]) begin
                right_bits = (right_bits >> (QUAN_4 * (1 << b)))
                           | (right_bits << (MSG_W - QUAN_4 * (1 << b)));
            end
        end
    end

    qsn_merge_inv_len17 u_merge (
        .left_lanes  (s1_left_q),
        .right_lanes (s1_right_q),
        .sel         (s1_sel_q),
        .merged      (merged)
    );

    always_comb begin
        s1_valid_d  = adv1 ? in_valid : s1_valid_q;
        s1_left_d   = s1_left_q;
        s1_right_d  = s1_right_q;
        s1_sel_d    = s1_sel_q;
        if (accept) begin
            s1_left_d  = left_bits;
            s1_right_d = right_bits;
            s1_sel_d   = merge_sel(s_eff);
        end
        s2_valid_d  = adv2 ? s1_valid_q : s2_valid_q;
        s2_data_d   = s2_data_q;
        if (adv2 && s1_valid_q) begin
            s2_data_d = merged;
        end
        shift_err_d = shift_err_q || (accept && bad_shift);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_left_q   <= '0;
            s1_right_q  <= '0;
            s1_sel_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            shift_err_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_left_q   <= s1_left_d;
            s1_right_q  <= s1_right_d;
            s1_sel_q    <= s1_sel_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            shift_err_q <= shift_err_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign msg_out   = s2_data_q;
    assign shift_err = shift_err_q;

endmodule

// File: tb/tb_qsn_inv_shift_len17.sv
// Scoreboard bench for the inverse QSN shifter: the driver queues expected
// beats, an independent monitor pops and compares on every emitted beat.
module tb_qsn_inv_shift_len17;

    localparam int L = 17;
    localparam int Q = 4;
    localparam int W = L * Q;

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   msg_in = '0;
    logic [4:0]     shift_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   msg_out;
    logic           shift_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int emit_cnt = 0;
    int emit_cyc = 0;
    int prev_emit_cyc = 0;
    int acc_cyc = 0;
    int rdy_mode = 0;
    int e0;
    logic [W-1:0] last_out = '0;
    logic [W-1:0] held = '0;
    bit held_v = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pat, pat2, pa, pb, rnd;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    qsn_inv_shift_len17 dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg_in    (msg_in),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .msg_out   (msg_out),
        .shift_err (shift_err)
    );

    function automatic logic [W-1:0] ref_rot(logic [W-1:0] m, int s);
        logic [W-1:0] r;
        if (s >= L) s = 0;
        for (int j = 0; j < L; j++) r[j*Q +: Q] = m[((j - s + L) % L)*Q +: Q];
        return r;
    endfunction

    function automatic logic [3:0] lane(logic [W-1:0] v, int i);
        return v[i*Q +: Q];
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(logic [W-1:0] m, logic [4:0] s);
        bit done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge sys_clk);
            in_valid = 1'b1; msg_in = m; shift_in = s;
            #4;
            if (in_ready) begin
                done = 1;
                acc_cyc = cyc;
                exp_q.push_back(ref_rot(m, int'(s)));
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, need 1");
        end
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_emit(int target);
        for (int t = 0; t < 40 && emit_cnt < target; t++) @(negedge sys_clk);
        #4;
        if (emit_cnt < target) begin
            n_vec++; n_err++;
            $display("FAIL emit_timeout: emitted %0d need %0d", emit_cnt, target);
        end
    endtask

    task automatic drain();
        bit ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge sys_clk); #4;
            if (exp_q.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d beats still pending, need 0", exp_q.size());
        end
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares emitted beats and checks output stability while stalled.
    initial begin
        forever begin
            @(negedge sys_clk); #4;
            if (rst) begin
                held_v = 0;
                continue;
            end
            if (held_v) begin
                chk("hold_data", msg_out, held);
                chk("hold_valid", W'(out_valid), W'(1));
                held_v = 0;
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_beat: got %h with no beat pending", msg_out);
                    end else begin
                        chk("beat", msg_out, exp_q.pop_front());
                    end
                    emit_cnt++;
                    prev_emit_cyc = emit_cyc;
                    emit_cyc = cyc;
                    last_out = msg_out;
                end else begin
                    held = msg_out;
                    held_v = 1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < L; i++) begin
            pat[i*Q +: Q]  = 4'(i % 16);
            pat2[i*Q +: Q] = 4'((3*i + 1) % 16);
            pa[i*Q +: Q]   = 4'((i + 5) % 16);
            pb[i*Q +: Q]   = 4'((15 - i) & 15);
        end

        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        #4;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_msg_out", msg_out, W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_shift_err", W'(shift_err), W'(0));

        // shift 3 on a lane-index pattern
        e0 = emit_cnt;
        send(pat, 5'd3);
        wait_emit(e0 + 1);
        chk("s3_lane0", W'(lane(last_out, 0)), W'(4'hE));
        chk("s3_lane3", W'(lane(last_out, 3)), W'(4'h0));
        chk("s3_lane16", W'(lane(last_out, 16)), W'(4'hD));
        chk("latency", W'(emit_cyc - acc_cyc), W'(2));
        chk("s3_shift_err", W'(shift_err), W'(0));

        // shifts 0 and 16 back to back
        e0 = emit_cnt;
        send(pat, 5'd0);
        send(pat, 5'd16);
        wait_emit(e0 + 2);
        chk("s16_lane0", W'(lane(last_out, 0)), W'(4'h1));
        chk("s16_lane16", W'(lane(last_out, 16)), W'(4'h0));
        chk("throughput", W'(emit_cyc - prev_emit_cyc), W'(1));
        drain();

        // backpressure: three beats offered while out_ready is held low
        e0 = emit_cnt;
        rdy_mode = 1;
        send(pat2, 5'd1);
        send(pat2, 5'd2);
        for (int t = 0; t < 2; t++) begin
            @(negedge sys_clk);
            in_valid = 1'b1; msg_in = pat2; shift_in = 5'd5;
            #4;
            chk("in_ready_full", W'(in_ready), W'(0));
        end
        rdy_mode = 0;
        send(pat2, 5'd5);
        wait_emit(e0 + 3);
        drain();
        chk("stall_beat_count", W'(emit_cnt - e0), W'(3));

        // illegal shift falls back to identity and sets the sticky flag
        e0 = emit_cnt;
        send(pat, 5'd20);
        wait_emit(e0 + 1);
        chk("bad_identity", last_out, pat);
        chk("bad_shift_err", W'(shift_err), W'(1));
        send(pat2, 5'd4);
        wait_emit(e0 + 2);
        chk("err_sticky", W'(shift_err), W'(1));
        drain();

        // reset with both stages full
        rdy_mode = 1;
        send(pa, 5'd7);
        send(pb, 5'd9);
        @(negedge sys_clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge sys_clk); #4;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_msg_out", msg_out, W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(1));
        @(negedge sys_clk);
        rst = 1'b0;
        rdy_mode = 0;
        e0 = emit_cnt;
        repeat (6) @(negedge sys_clk);
        #4;
        chk("no_stale_beat", W'(emit_cnt - e0), W'(0));
        chk("rst_clears_err", W'(shift_err), W'(0));

        // random lanes and shifts with random backpressure
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < L; i++) rnd[i*Q +: Q] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) @(negedge sys_clk);
            send(rnd, 5'($urandom_range(0, 16)));
        end
        rdy_mode = 0;
        drain();
        chk("queue_empty", W'(exp_q.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qsn_inv_shift_len17.md
Name: qsn_inv_shift_len17

Overview:
- Pipelined inverse cyclic shifter for 17-lane quantised LDPC messages (Pc=17, q=4).
- Undoes the forward QSN permutation on the write-back path, from the decoder units to the memory.
- Built as two QSN half-networks, one left and one right, plus a merge stage driven by a generated select mask.
- Two register stages with valid/ready flow control, so it can sit between the layered decoder core and the message RAM.

Parameters:
- LANES, 17, number of message lanes (submatrix size).
- QUAN, 4, bits per lane message.
- SHIFT_W, 5, width of the shift factor.

Ports:
- sys_clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- msg_in  input  LANES*QUAN  lane i occupies bits [i*QUAN +: QUAN].
- shift_in  input  SHIFT_W  inverse shift factor, legal range 0..16.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- msg_out  output  LANES*QUAN  de-rotated lanes.
- shift_err  output  1  sticky flag: an illegal shift was accepted.

Behaviour:
- Function: msg_out lane j = msg_in lane ((j - s) mod 17), where s = shift_in captured with the beat.
- Illegal shift: if shift_in >= 17 on an accepted beat, use s = 0 (identity) and set shift_err. shift_err stays 1 until rst.
- Accept and emit rules:
  - A beat is accepted when in_valid && in_ready.
  - A beat is emitted when out_valid && out_ready.
- Stage 1 registers (s1_valid, s1_left, s1_right, s1_sel):
  - s1_left: lanes rotated by the left half-network.
  - s1_right: lanes rotated by the right half-network.
  - s1_sel: 16-bit merge mask, bit k = 1 when lane k takes the left-network value, i.e. k >= s for the inverse mapping.
- Stage 2 registers (s2_valid, s2_data): s2_data = merge(s1_left, s1_right, s1_sel). msg_out = s2_data, out_valid = s2_valid.
- Latency: 2 cycles from acceptance to out_valid when there is no backpressure.
- Throughput: 1 beat per cycle.
- Advance conditions:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, which is combinational from out_ready and the stage valids.
- Data registers load only on advance. Valid registers clear when their stage drains and nothing refills it.
- Simultaneous accept, emit and full-pipe refill in one cycle: all legal, no bubble is inserted, no beat is lost or duplicated.
- While out_ready = 0, msg_out and out_valid hold stable.
- in_valid = 0: no state change other than draining.
- Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, msg_out = 0, shift_err = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and none is emitted afterwards. Data registers are zeroed too, for deterministic simulation.
- Boundaries:
  - s = 0: output equals input.
  - s = 16: lane j = in lane (j+1) mod 17.
  - Lane 16 comes from the right network when s > 0; it is the fixed pass-through lane of the merge.

Decomposition:
- Shared package qsn_pkg holds:
  - constants LANES_17, QUAN_4, SHIFT_W_5;
  - the lane-vector typedef;
  - a function computing the merge select mask from s.
- One natural sub-module: qsn_merge_inv_len17. It is the combinational 17-lane merge, with 16 mux lanes plus one fixed lane, and is instantiated in stage 2.
- The left and right half-networks stay inline as log2 barrel-shift stages.

Test Plan:
- Lane pattern in lane i = i mod 16, shift 3, out_ready = 1 -> after 2 cycles, out lane 0 = 0xE, lane 3 = 0x0, lane 16 = 0xD; shift_err = 0.
- Same pattern with shift 0 and shift 16 on back-to-back beats -> first output is identity; second has lane 0 = 1 and lane 16 = 0 (lane 16 = in lane 0); throughput 1 beat per cycle.
- Hold out_ready = 0 for 4 cycles while offering 3 beats with shifts 1, 2, 5 -> in_ready drops after 2 beats; the output holds stable; on release, 3 correctly rotated beats arrive in order with no loss or duplication.
- shift_in = 20 on one beat -> output equals input; shift_err = 1 and stays set through later legal beats until rst.
- Assert rst with both stages full -> next cycle out_valid = 0, msg_out = 0, in_ready = 1; no stale beat emitted after release.
- Randomised lanes and shifts 0..16 against a reference model of the rotation, with random out_ready toggling -> all beats match and arrive in order.
